// File: rtl/qos_pkg.sv
// Shared types and constants for the weighted round-robin queue arbiter.
package qos_pkg;

  localparam int unsigned NUM_QUEUES = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CREDIT_W   = 4;

  localparam int unsigned DEF_W0 = 4;
  localparam int unsigned DEF_W1 = 3;
  localparam int unsigned DEF_W2 = 2;
  localparam int unsigned DEF_W3 = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Credit loaded on selection: weight-1, with a zero weight treated as one.
  function automatic logic [CREDIT_W-1:0] credit_reload(input int unsigned w);
    if (w == 0) begin
      return '0;
    end
    return CREDIT_W'(w - 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request bit at or after start, wrapping.
module rr_pick
  import qos_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [IDX_W-1:0]      start,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);

  logic [IDX_W-1:0] cand;

  // Scan from start; the index counter wraps naturally at NUM_QUEUES.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
      cand = start + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Weighted round-robin arbiter draining four queues into one downstream FIFO.
module round_robin_arbiter
  import qos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned W0         = DEF_W0,
  parameter int unsigned W1         = DEF_W1,
  parameter int unsigned W2         = DEF_W2,
  parameter int unsigned W3         = DEF_W3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_QUEUES-1:0] EMPTY_IN,
  input  logic [NUM_QUEUES-1:0] ALMOST_EMPTY_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN0,
  input  logic [DATA_WIDTH-1:0] DATA_IN1,
  input  logic [DATA_WIDTH-1:0] DATA_IN2,
  input  logic [DATA_WIDTH-1:0] DATA_IN3,
  input  logic                  FULL_IN,
  input  logic                  ALMOST_FULL_IN,
  output logic [NUM_QUEUES-1:0] POP_OUT,
  output logic                  PUSH_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic [IDX_W-1:0]      GRANT_OUT,
  output logic                  IDLE_OUT
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                push_q;
  logic [IDX_W-1:0]    grant_q;

  logic [NUM_QUEUES-1:0] req;
  logic                  en;
  logic [IDX_W-1:0]      start;
  logic [IDX_W-1:0]      pick;
  logic                  found;
  logic [CREDIT_W-1:0]   reload_pick;
  logic                  pop_valid;
  logic [IDX_W-1:0]      pop_idx;

  // Almost-empty is informational only; kept visible so it is not flagged unused.
  logic unused_status;
  assign unused_status = ^ALMOST_EMPTY_IN;

  // Almost-full gates new pops so the one in-flight push always has room; reset blocks pops.
  assign req = ~EMPTY_IN;
  assign en  = ~FULL_IN & ~ALMOST_FULL_IN & ~RESET;

  // IDLE searches from PTR; a rotation in SERVE searches from CUR+1 so CUR is eligible last.
  assign start = (state_q == SERVE) ? IDX_W'(cur_q + 2'd1) : ptr_q;

  rr_pick u_rr_pick (
    .req   (req),
    .start (start),
    .idx   (pick),
    .found (found)
  );

  // Credit to load for whichever queue the search selected.
  always_comb begin
    case (pick)
      2'd0:    reload_pick = credit_reload(W0);
      2'd1:    reload_pick = credit_reload(W1);
      2'd2:    reload_pick = credit_reload(W2);
      default: reload_pick = credit_reload(W3);
    endcase
  end

  // Next-state and pop decision.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    pop_valid = 1'b0;
    pop_idx   = cur_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          pop_valid = 1'b1;
          pop_idx   = pick;
          cur_d     = pick;
          credit_d  = reload_pick;
          state_d   = SERVE;
        end
      end
      SERVE: begin
        if (en) begin
          if (req[cur_q] && (credit_q != '0)) begin
            pop_valid = 1'b1;
            pop_idx   = cur_q;
            credit_d  = credit_q - 4'd1;
          end else begin
            ptr_d = IDX_W'(cur_q + 2'd1);
            if (found) begin
              pop_valid = 1'b1;
              pop_idx   = pick;
              cur_d     = pick;
              credit_d  = reload_pick;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  assign POP_OUT = pop_valid ? (NUM_QUEUES'(1) << pop_idx) : '0;

  // State registers; the push strobe and grant index trail the pop by one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      push_q   <= 1'b0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      push_q   <= pop_valid;
      if (pop_valid) begin
        grant_q <= pop_idx;
      end
    end
  end

  // Queue read data arrives the cycle after the pop, aligned with the push strobe.
  always_comb begin
    DATA_OUT = '0;
    if (push_q) begin
      case (grant_q)
        2'd0:    DATA_OUT = DATA_IN0;
        2'd1:    DATA_OUT = DATA_IN1;
        2'd2:    DATA_OUT = DATA_IN2;
        default: DATA_OUT = DATA_IN3;
      endcase
    end
  end

  assign PUSH_OUT  = push_q;
  assign GRANT_OUT = grant_q;
  assign IDLE_OUT  = (state_q == IDLE);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for the weighted round-robin arbiter.
module tb_round_robin_arbiter;

  localparam int unsigned DW = 10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [3:0]    EMPTY_IN = 4'hF;
  logic [3:0]    ALMOST_EMPTY_IN = 4'h0;
  logic [DW-1:0] DATA_IN0;
  logic [DW-1:0] DATA_IN1;
  logic [DW-1:0] DATA_IN2;
  logic [DW-1:0] DATA_IN3;
  logic          FULL_IN = 1'b0;
  logic          ALMOST_FULL_IN = 1'b0;
  logic [3:0]    POP_OUT;
  logic          PUSH_OUT;
  logic [DW-1:0] DATA_OUT;
  logic [1:0]    GRANT_OUT;
  logic          IDLE_OUT;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] dat [4];
  int            seq [10];

  initial begin
    dat[0] = 10'h2A5;
    dat[1] = 10'h15A;
    dat[2] = 10'h3C3;
    dat[3] = 10'h0F0;
  end

  assign DATA_IN0 = dat[0];
  assign DATA_IN1 = dat[1];
  assign DATA_IN2 = dat[2];
  assign DATA_IN3 = dat[3];

  always #5 CLK = ~CLK;

  round_robin_arbiter #(
    .DATA_WIDTH (DW),
    .W0         (4),
    .W1         (3),
    .W2         (2),
    .W3         (1)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .EMPTY_IN        (EMPTY_IN),
    .ALMOST_EMPTY_IN (ALMOST_EMPTY_IN),
    .DATA_IN0        (DATA_IN0),
    .DATA_IN1        (DATA_IN1),
    .DATA_IN2        (DATA_IN2),
    .DATA_IN3        (DATA_IN3),
    .FULL_IN         (FULL_IN),
    .ALMOST_FULL_IN  (ALMOST_FULL_IN),
    .POP_OUT         (POP_OUT),
    .PUSH_OUT        (PUSH_OUT),
    .DATA_OUT        (DATA_OUT),
    .GRANT_OUT       (GRANT_OUT),
    .IDLE_OUT        (IDLE_OUT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Hold reset over two edges with all queues empty, then release with the given empties.
  task automatic restart(input logic [3:0] empties);
    RESET = 1'b1;
    EMPTY_IN = 4'hF;
    FULL_IN = 1'b0;
    ALMOST_FULL_IN = 1'b0;
    cyc();
    cyc();
    EMPTY_IN = empties;
    RESET = 1'b0;
  endtask

  initial begin
    seq = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

    // Reset values, with every queue requesting while reset is held.
    RESET = 1'b1;
    EMPTY_IN = 4'h0;
    cyc();
    cyc();
    #2;
    chk("rst_pop", 32'(POP_OUT), 32'h0);
    chk("rst_push", 32'(PUSH_OUT), 32'h0);
    chk("rst_grant", 32'(GRANT_OUT), 32'h0);
    chk("rst_data", 32'(DATA_OUT), 32'h0);
    chk("rst_idle", 32'(IDLE_OUT), 32'h1);
    RESET = 1'b0;
    #1;

    // All queues busy: q0x4, q1x3, q2x2, q3x1 repeating, push continuous.
    for (int k = 0; k < 20; k++) begin
      #2;
      chk($sformatf("wrr_pop%0d", k), 32'(POP_OUT), 32'(1) << seq[k % 10]);
      if (k == 0) begin
        chk("wrr_push0", 32'(PUSH_OUT), 32'h0);
        chk("wrr_idle0", 32'(IDLE_OUT), 32'h1);
      end else begin
        chk($sformatf("wrr_push%0d", k), 32'(PUSH_OUT), 32'h1);
        chk($sformatf("wrr_grant%0d", k), 32'(GRANT_OUT), 32'(seq[(k - 1) % 10]));
        chk($sformatf("wrr_data%0d", k), 32'(DATA_OUT), 32'(dat[seq[(k - 1) % 10]]));
        chk($sformatf("wrr_idle%0d", k), 32'(IDLE_OUT), 32'h0);
      end
      cyc();
    end

    // Only q2 holds 5 words: five back-to-back pops, then back to idle.
    restart(4'b1011);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("q2_pop%0d", k), 32'(POP_OUT), 32'h4);
      cyc();
    end
    EMPTY_IN = 4'hF;
    #2;
    chk("q2_drain_pop", 32'(POP_OUT), 32'h0);
    chk("q2_drain_push", 32'(PUSH_OUT), 32'h1);
    chk("q2_drain_grant", 32'(GRANT_OUT), 32'h2);
    chk("q2_drain_data", 32'(DATA_OUT), 32'(dat[2]));
    cyc();
    #2;
    chk("q2_idle", 32'(IDLE_OUT), 32'h1);
    chk("q2_idle_push", 32'(PUSH_OUT), 32'h0);
    chk("q2_idle_data", 32'(DATA_OUT), 32'h0);
    cyc();

    // Almost-full for 3 cycles while q0 has credit 2 left.
    restart(4'h0);
    #2;
    chk("af_pop_a", 32'(POP_OUT), 32'h1);
    cyc();
    #2;
    chk("af_pop_b", 32'(POP_OUT), 32'h1);
    cyc();
    ALMOST_FULL_IN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("af_hold%0d", k), 32'(POP_OUT), 32'h0);
      chk($sformatf("af_push%0d", k), 32'(PUSH_OUT), (k == 0) ? 32'h1 : 32'h0);
      cyc();
    end
    ALMOST_FULL_IN = 1'b0;
    #2;
    chk("af_pop_c", 32'(POP_OUT), 32'h1);
    cyc();
    #2;
    chk("af_pop_d", 32'(POP_OUT), 32'h1);
    cyc();
    #2;
    chk("af_pop_q1", 32'(POP_OUT), 32'h2);
    cyc();
    FULL_IN = 1'b1;
    #2;
    chk("full_hold", 32'(POP_OUT), 32'h0);
    chk("full_push_inflight", 32'(PUSH_OUT), 32'h1);
    cyc();
    FULL_IN = 1'b0;
    #2;
    chk("full_resume_q1", 32'(POP_OUT), 32'h2);
    chk("full_resume_push", 32'(PUSH_OUT), 32'h0);
    cyc();

    // q3 exhausts its single credit; PTR wraps and q0 wins over q2.
    restart(4'b0111);
    #2;
    chk("wrap_pop_q3", 32'(POP_OUT), 32'h8);
    cyc();
    EMPTY_IN = 4'b0010;
    #2;
    chk("wrap_pop_q0", 32'(POP_OUT), 32'h1);
    chk("wrap_grant3", 32'(GRANT_OUT), 32'h3);
    chk("wrap_data3", 32'(DATA_OUT), 32'(dat[3]));
    cyc();
    #2;
    chk("wrap_push", 32'(PUSH_OUT), 32'h1);
    chk("wrap_grant0", 32'(GRANT_OUT), 32'h0);
    chk("wrap_data0", 32'(DATA_OUT), 32'(dat[0]));
    cyc();

    // Reset right after a q1 pop discards the pending push.
    restart(4'b1101);
    #2;
    chk("rp_pop_q1", 32'(POP_OUT), 32'h2);
    cyc();
    RESET = 1'b1;
    #2;
    chk("rp_push", 32'(PUSH_OUT), 32'h0);
    chk("rp_grant", 32'(GRANT_OUT), 32'h0);
    chk("rp_data", 32'(DATA_OUT), 32'h0);
    chk("rp_idle", 32'(IDLE_OUT), 32'h1);
    chk("rp_pop", 32'(POP_OUT), 32'h0);
    cyc();
    EMPTY_IN = 4'b1100;
    RESET = 1'b0;
    #2;
    chk("rp_next_q0", 32'(POP_OUT), 32'h1);
    chk("rp_next_push", 32'(PUSH_OUT), 32'h0);
    cyc();
    #2;
    chk("rp_after_push", 32'(PUSH_OUT), 32'h1);
    chk("rp_after_grant", 32'(GRANT_OUT), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
